// File: rtl/if_id_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : if_id_ctrl                                                   |
// | Description : IF/ID pipeline register with ID-stage branch/jump resolution, |
// |               hazard stall, redirect flush and saturating event counters.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module if_id_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instruction_if,
  input  logic [31:0]      PC_if,
  input  logic             IF_flush,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_dst,
  input  logic             mem_mem_read,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_dst,
  input  logic [31:0]      mem_alu_result,
  output logic             Branch,
  output logic             Jump,
  output logic [31:0]      JumpAddr,
  output logic             IFWrite,
  output logic [31:0]      Instruction_id,
  output logic [31:0]      PC4_id,
  output logic             valid_id,
  output logic             id_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [5:0]       c_OP_RTYPE = 6'b000000;
  localparam logic [5:0]       c_OP_BEQ   = 6'b000100;
  localparam logic [5:0]       c_OP_BNE   = 6'b000101;
  localparam logic [5:0]       c_OP_J     = 6'b000010;
  localparam logic [5:0]       c_OP_JAL   = 6'b000011;
  localparam logic [5:0]       c_OP_SW    = 6'b101011;
  localparam logic [5:0]       c_FN_JR    = 6'b001000;
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc_q, pc_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt;
  logic        w_is_rtype, w_is_beq, w_is_bne, w_is_j, w_is_jal, w_is_jr, w_uses_rt;
  logic        w_ex_src_hit, w_mem_src_hit, w_load_use, w_branch_haz, w_stall;
  logic        w_fwd_ok;
  logic [31:0] w_op_a, w_op_b, w_pc4, w_br_off;

  assign w_op       = instr_q[31:26];
  assign w_funct    = instr_q[5:0];
  assign w_rs       = instr_q[25:21];
  assign w_rt       = instr_q[20:16];
  assign w_is_rtype = (w_op == c_OP_RTYPE);
  assign w_is_beq   = (w_op == c_OP_BEQ);
  assign w_is_bne   = (w_op == c_OP_BNE);
  assign w_is_j     = (w_op == c_OP_J);
  assign w_is_jal   = (w_op == c_OP_JAL);
  assign w_is_jr    = w_is_rtype && (w_funct == c_FN_JR);
  assign w_uses_rt  = w_is_rtype || w_is_beq || w_is_bne || (w_op == c_OP_SW);

  // $0 is hardwired zero, so it can never be a producer for a hazard.
  assign w_ex_src_hit  = (ex_dst != 5'd0) &&
                         ((ex_dst == w_rs) || (w_uses_rt && (ex_dst == w_rt)));
  assign w_mem_src_hit = (mem_dst != 5'd0) &&
                         ((mem_dst == w_rs) || (w_uses_rt && (mem_dst == w_rt)));

  assign w_load_use   = ex_mem_read && w_ex_src_hit;
  assign w_branch_haz = (w_is_beq || w_is_bne || w_is_jr) &&
                        ((ex_reg_write && w_ex_src_hit) || (mem_mem_read && w_mem_src_hit));
  assign w_stall      = valid_q && (w_load_use || w_branch_haz);

  assign w_fwd_ok = mem_reg_write && !mem_mem_read && (mem_dst != 5'd0);
  assign w_op_a   = (w_fwd_ok && (mem_dst == w_rs)) ? mem_alu_result : rs_data;
  assign w_op_b   = (w_fwd_ok && (mem_dst == w_rt)) ? mem_alu_result : rt_data;

  assign w_pc4    = pc_q + 32'd4;
  assign w_br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  assign Branch = valid_q && !w_stall &&
                  ((w_is_beq && (w_op_a == w_op_b)) || (w_is_bne && (w_op_a != w_op_b)));
  assign Jump   = valid_q && !w_stall && (w_is_j || w_is_jal || w_is_jr);

  always_comb begin
    JumpAddr = w_pc4;
    if (w_is_jr) begin
      JumpAddr = w_op_a;
    end else if (w_is_j || w_is_jal) begin
      JumpAddr = {w_pc4[31:28], instr_q[25:0], 2'b00};
    end else if (Branch) begin
      JumpAddr = w_pc4 + w_br_off;
    end
  end

  assign IFWrite        = !w_stall;
  assign id_bubble      = w_stall || !valid_q;
  assign Instruction_id = instr_q;
  assign PC4_id         = w_pc4;
  assign valid_id       = valid_q;
  assign stall_cnt      = stall_cnt_q;
  assign flush_cnt      = flush_cnt_q;

  always_comb begin
    instr_d     = instr_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (reset) begin
      instr_d     = 32'd0;
      pc_d        = 32'd0;
      valid_d     = 1'b0;
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      // Flush takes precedence over a stall so a redirect is never lost.
      if (IF_flush) begin
        instr_d = 32'd0;
        pc_d    = PC_if;
        valid_d = 1'b0;
      end else if (!w_stall) begin
        instr_d = Instruction_if;
        pc_d    = PC_if;
        valid_d = 1'b1;
      end
      if (w_stall && (stall_cnt_q != c_CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + c_CNT_ONE;
      end
      if (IF_flush && (flush_cnt_q != c_CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + c_CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    instr_q     <= instr_d;
    pc_q        <= pc_d;
    valid_q     <= valid_d;
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_if_id_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_if_id_ctrl                                                |
// | Description : Directed self-checking bench for if_id_ctrl.                 |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_if_id_ctrl;

  localparam int CNT_W = 16;

  localparam logic [31:0] c_ADD_A  = 32'h00C72820; // add $5,$6,$7
  localparam logic [31:0] c_ADD_LU = 32'h00441820; // add $3,$2,$4
  localparam logic [31:0] c_BEQ11  = 32'h10210003; // beq $1,$1,+3
  localparam logic [31:0] c_BNE56  = 32'h14A60002; // bne $5,$6,+2
  localparam logic [31:0] c_J40    = 32'h08000040; // j 0x40
  localparam logic [31:0] c_JR31   = 32'h03E00008; // jr $31
  localparam logic [31:0] c_BEQ00  = 32'h10000004; // beq $0,$0,+4

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      Instruction_if, PC_if;
  logic             IF_flush;
  logic [31:0]      rs_data, rt_data;
  logic             ex_mem_read, ex_reg_write;
  logic [4:0]       ex_dst;
  logic             mem_mem_read, mem_reg_write;
  logic [4:0]       mem_dst;
  logic [31:0]      mem_alu_result;
  logic             Branch, Jump, IFWrite, valid_id, id_bubble;
  logic [31:0]      JumpAddr, Instruction_id, PC4_id;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  if_id_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .Instruction_if(Instruction_if), .PC_if(PC_if), .IF_flush(IF_flush),
    .rs_data(rs_data), .rt_data(rt_data),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_dst(ex_dst),
    .mem_mem_read(mem_mem_read), .mem_reg_write(mem_reg_write), .mem_dst(mem_dst),
    .mem_alu_result(mem_alu_result),
    .Branch(Branch), .Jump(Jump), .JumpAddr(JumpAddr), .IFWrite(IFWrite),
    .Instruction_id(Instruction_id), .PC4_id(PC4_id), .valid_id(valid_id),
    .id_bubble(id_bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hazard_inputs();
    ex_mem_read    = 1'b0;
    ex_reg_write   = 1'b0;
    ex_dst         = 5'd0;
    mem_mem_read   = 1'b0;
    mem_reg_write  = 1'b0;
    mem_dst        = 5'd0;
    mem_alu_result = 32'd0;
    rs_data        = 32'd0;
    rt_data        = 32'd0;
  endtask

  initial begin
    reset = 1'b1; IF_flush = 1'b0;
    Instruction_if = 32'd0; PC_if = 32'd0;
    clear_hazard_inputs();
    tick(); tick();

    // Reset state
    chk("rst_instr",  Instruction_id, 32'd0);
    chk("rst_pc4",    PC4_id, 32'd4);
    chk("rst_valid",  valid_id, 1'b0);
    chk("rst_branch", Branch, 1'b0);
    chk("rst_jump",   Jump, 1'b0);
    chk("rst_jaddr",  JumpAddr, 32'd4);
    chk("rst_ifw",    IFWrite, 1'b1);
    chk("rst_bubble", id_bubble, 1'b1);
    chk("rst_scnt",   stall_cnt, 32'd0);
    chk("rst_fcnt",   flush_cnt, 32'd0);

    // Straight-line code
    reset = 1'b0; Instruction_if = c_ADD_A; PC_if = 32'h0; #1;
    chk("sl0_valid", valid_id, 1'b0);
    tick(); PC_if = 32'h4; #1;
    chk("sl1_valid", valid_id, 1'b1);
    chk("sl1_pc4",   PC4_id, 32'h4);
    chk("sl1_instr", Instruction_id, c_ADD_A);
    chk("sl1_ifw",   IFWrite, 1'b1);
    tick(); PC_if = 32'h8; #1;
    chk("sl2_pc4",   PC4_id, 32'h8);
    chk("sl2_ifw",   IFWrite, 1'b1);
    tick(); Instruction_if = c_ADD_LU; PC_if = 32'hC; #1;
    chk("sl3_pc4",   PC4_id, 32'hC);
    chk("sl3_scnt",  stall_cnt, 32'd0);

    // Load-use: lw $2 in EX, add $3,$2,$4 in ID
    tick();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd2;
    Instruction_if = c_ADD_A; PC_if = 32'h10; #1;
    chk("lu_ifw",    IFWrite, 1'b0);
    chk("lu_bubble", id_bubble, 1'b1);
    tick();
    clear_hazard_inputs(); #1;
    chk("lu_hold_instr", Instruction_id, c_ADD_LU);
    chk("lu_hold_pc4",   PC4_id, 32'h10);
    chk("lu_ifw_after",  IFWrite, 1'b1);
    chk("lu_bub_after",  id_bubble, 1'b0);
    chk("lu_scnt",       stall_cnt, 32'd1);

    // beq $1,$1,+3 at 0x10 -> taken to 0x20, delay slot squashed
    Instruction_if = c_BEQ11; PC_if = 32'h10;
    tick();
    rs_data = 32'd5; rt_data = 32'd5;
    IF_flush = 1'b1; Instruction_if = c_ADD_A; PC_if = 32'h14; #1;
    chk("beq_branch", Branch, 1'b1);
    chk("beq_jump",   Jump, 1'b0);
    chk("beq_jaddr",  JumpAddr, 32'h20);
    tick();
    IF_flush = 1'b0; Instruction_if = c_BNE56; PC_if = 32'h20; #1;
    chk("fl_instr",  Instruction_id, 32'd0);
    chk("fl_valid",  valid_id, 1'b0);
    chk("fl_fcnt",   flush_cnt, 32'd1);
    chk("fl_bubble", id_bubble, 1'b1);
    chk("fl_branch", Branch, 1'b0);

    // bne with rs forwarded from MEM ALU result: 7 == 7 -> not taken
    tick();
    mem_reg_write = 1'b1; mem_dst = 5'd5; mem_alu_result = 32'd7;
    rs_data = 32'd0; rt_data = 32'd7;
    Instruction_if = c_BNE56; PC_if = 32'h24; #1;
    chk("bnef_branch", Branch, 1'b0);
    chk("bnef_ifw",    IFWrite, 1'b1);
    chk("bnef_jaddr",  JumpAddr, 32'h24);

    // Same bne with producer still in EX -> one stall, then resolves
    tick();
    clear_hazard_inputs();
    ex_reg_write = 1'b1; ex_dst = 5'd5; rt_data = 32'd7; #1;
    chk("bnes_ifw",    IFWrite, 1'b0);
    chk("bnes_branch", Branch, 1'b0);
    tick();
    clear_hazard_inputs();
    mem_reg_write = 1'b1; mem_dst = 5'd5; mem_alu_result = 32'd7; rt_data = 32'd7;
    Instruction_if = c_J40; PC_if = 32'h30; #1;
    chk("bnes2_ifw",    IFWrite, 1'b1);
    chk("bnes2_branch", Branch, 1'b0);
    chk("bnes2_scnt",   stall_cnt, 32'd2);
    chk("bnes2_pc4",    PC4_id, 32'h28);

    // j 0x40 at 0x30
    tick();
    clear_hazard_inputs();
    IF_flush = 1'b1; Instruction_if = c_JR31; PC_if = 32'h34; #1;
    chk("j_jump",  Jump, 1'b1);
    chk("j_jaddr", JumpAddr, 32'h100);
    chk("j_br",    Branch, 1'b0);
    tick();
    IF_flush = 1'b0; Instruction_if = c_JR31; PC_if = 32'h100; #1;
    chk("j_fcnt",  flush_cnt, 32'd2);
    chk("j_valid", valid_id, 1'b0);

    // jr $31 with rs_data = 0x44
    tick();
    rs_data = 32'h44; IF_flush = 1'b1; #1;
    chk("jr_jump",  Jump, 1'b1);
    chk("jr_jaddr", JumpAddr, 32'h44);
    tick();
    IF_flush = 1'b0; rs_data = 32'd0;
    Instruction_if = c_BEQ00; PC_if = 32'hFFFF_FFF0; #1;
    chk("jr_fcnt", flush_cnt, 32'd3);

    // beq $0,$0,+4 at 0xFFFFFFF0: target wraps; $0 producers never hazard/forward
    tick();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd0;
    mem_mem_read = 1'b1; mem_reg_write = 1'b1; mem_dst = 5'd0; mem_alu_result = 32'd5; #1;
    chk("wrap_ifw",    IFWrite, 1'b1);
    chk("wrap_branch", Branch, 1'b1);
    chk("wrap_jaddr",  JumpAddr, 32'h4);

    // Reset on the redirect cycle
    reset = 1'b1; IF_flush = 1'b1;
    tick();
    clear_hazard_inputs();
    IF_flush = 1'b0; Instruction_if = 32'd0; PC_if = 32'd0; #1;
    chk("rr_branch", Branch, 1'b0);
    chk("rr_jump",   Jump, 1'b0);
    chk("rr_jaddr",  JumpAddr, 32'd4);
    chk("rr_pc4",    PC4_id, 32'd4);
    chk("rr_valid",  valid_id, 1'b0);
    chk("rr_instr",  Instruction_id, 32'd0);
    chk("rr_ifw",    IFWrite, 1'b1);
    chk("rr_bubble", id_bubble, 1'b1);
    chk("rr_scnt",   stall_cnt, 32'd0);
    chk("rr_fcnt",   flush_cnt, 32'd0);

    // Long load-use stall: counter saturates at all-ones
    reset = 1'b0; Instruction_if = c_ADD_LU; PC_if = 32'h200;
    tick();
    ex_mem_read = 1'b1; ex_dst = 5'd2; Instruction_if = c_ADD_A; PC_if = 32'h204; #1;
    chk("sat_ifw",    IFWrite, 1'b0);
    chk("sat_bubble", id_bubble, 1'b1);
    repeat (65534) tick();
    chk("sat_pre", stall_cnt, 32'hFFFE);
    repeat (4) tick();
    chk("sat_max",   stall_cnt, 32'hFFFF);
    chk("sat_instr", Instruction_id, c_ADD_LU);
    chk("sat_pc4",   PC4_id, 32'h204);
    chk("sat_fcnt",  flush_cnt, 32'd0);

    // Flush asserted during a stall: flush wins
    IF_flush = 1'b1; PC_if = 32'h300;
    tick();
    IF_flush = 1'b0; #1;
    chk("fs_valid", valid_id, 1'b0);
    chk("fs_instr", Instruction_id, 32'd0);
    chk("fs_pc4",   PC4_id, 32'h304);
    chk("fs_fcnt",  flush_cnt, 32'd1);
    chk("fs_scnt",  stall_cnt, 32'hFFFF);
    chk("fs_ifw",   IFWrite, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_id_ctrl.md
Name: if_id_ctrl

Overview:
- ID-side partner of the instruction fetch stage in the 5-stage MIPS pipeline. It contains the IF/ID pipeline register and returns the fetch-control signals Branch, Jump, JumpAddr and IFWrite to the fetch stage.
- It resolves beq/bne/j/jal/jr in ID, with branch operand forwarding from MEM.
- It detects load-use and branch-operand hazards and stalls fetch on either.
- It flushes the instruction fetched behind a taken branch or jump, and keeps saturating stall and flush counters.

Parameters:
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- Instruction_if  in  32  instruction word from fetch
- PC_if  in  32  address of Instruction_if
- IF_flush  in  1  fetch-side flush (Branch||Jump, looped back)
- rs_data  in  32  register-file read port A (regfile bypasses same-cycle WB writes)
- rt_data  in  32  register-file read port B
- ex_mem_read  in  1  EX-stage instruction is lw
- ex_reg_write  in  1  EX-stage instruction writes a register
- ex_dst  in  5  EX-stage destination register
- mem_mem_read  in  1  MEM-stage instruction is lw
- mem_reg_write  in  1  MEM-stage instruction writes a register
- mem_dst  in  5  MEM-stage destination register
- mem_alu_result  in  32  MEM-stage ALU result (forwarding source)
- Branch  out  1  taken beq/bne in ID
- Jump  out  1  j/jal/jr in ID
- JumpAddr  out  32  redirect target
- IFWrite  out  1  PC and IF/ID load enable
- Instruction_id  out  32  IF/ID instruction
- PC4_id  out  32  PC_id+4 (jal link value)
- valid_id  out  1  IF/ID holds a real instruction
- id_bubble  out  1  ID/EX must load a NOP this cycle
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of flush cycles

Behaviour:
- Decode of Instruction_id, by opcode [31:26]:
  - beq = 000100, bne = 000101, j = 000010, jal = 000011, lw = 100011.
  - jr = opcode 000000 with funct 001000.
  - rs = [25:21], rt = [20:16].
  - uses_rt = R-type, beq, bne or sw (101011).
- Load-use hazard: ex_mem_read, ex_dst != 0, and ex_dst equals rs, or equals rt when uses_rt.
- Branch hazard: ID holds beq, bne or jr, and either condition holds:
  - ex_reg_write with ex_dst != 0 matching a source operand;
  - mem_mem_read with mem_dst != 0 matching a source operand.
- stall = valid_id & (load-use | branch hazard).
- Operand forwarding for the comparison and for jr:
  - opA = mem_alu_result if mem_reg_write & !mem_mem_read & mem_dst != 0 & mem_dst == rs; otherwise opA = rs_data.
  - opB is formed the same way against rt.
- Branch = valid_id & !stall & ((beq & opA==opB) | (bne & opA!=opB)).
- Jump = valid_id & !stall & (j | jal | jr).
- Branch, Jump and JumpAddr are combinational from IF/ID state and the inputs.
- JumpAddr, in priority order:
  - jr: opA.
  - j/jal: {PC4_id[31:28], Instruction_id[25:0], 2'b00}.
  - Branch: PC4_id + (signext(Instruction_id[15:0]) << 2), 32-bit wrap-around.
  - Otherwise: PC4_id.
- IFWrite = !stall. id_bubble = stall | !valid_id.
- IF/ID register update at posedge clk, priority order:
  - reset: Instruction_id=0, PC_id=0, valid_id=0, stall_cnt=0, flush_cnt=0.
  - IF_flush: Instruction_id=0 (NOP), valid_id=0, PC_id=PC_if. This squashes the delay-slot instruction. Redirect penalty is exactly one bubble.
  - stall: hold all IF/ID contents.
  - otherwise: Instruction_id=Instruction_if, PC_id=PC_if, valid_id=1.
- Reset-time outputs: PC4_id=4, Branch=0, Jump=0, JumpAddr=4, IFWrite=1, id_bubble=1.
- Stall and flush are mutually exclusive by construction, because stall forces Branch=Jump=0. If IF_flush is ever asserted during a stall, flush wins.
- Counters:
  - stall_cnt increments on every cycle with stall=1.
  - flush_cnt increments on every cycle with IF_flush=1.
  - Both saturate at all-ones and never wrap.
- Reset mid-stall or mid-redirect: the next state is the reset state. No redirect survives reset.
- Register $0 never causes a hazard or forwarding.

Test Plan:
- Reset then straight-line code: PC_if 0,4,8 with add instructions -> valid_id=1 from the second cycle; PC4_id=4,8,12; IFWrite=1 throughout; stall_cnt=0.
- lw $2 in EX (ex_mem_read=1, ex_dst=2), add $3,$2,$4 in ID -> exactly one cycle with IFWrite=0 and id_bubble=1; IF/ID held; stall_cnt=1.
- beq $1,$1,+3 at PC 0x10, no hazards -> Branch=1, JumpAddr=0x20. Next cycle: Instruction_id=0, valid_id=0, flush_cnt=1.
- bne with rs matched by MEM ALU result (mem_dst=5, mem_alu_result=7), rt_data=7 -> not taken, Branch=0, no flush. With ex_dst=5 & ex_reg_write=1 instead -> one stall cycle, then resolves.
- j 0x0000040 at PC 0x30 -> Jump=1, JumpAddr=0x00000100. jr $31 with rs_data=0x44 -> JumpAddr=0x44.
- Branch at PC 0xFFFFFFF0 with offset 0x0004 -> JumpAddr=0x00000004 (wraps). Reset asserted on the redirect cycle -> all outputs return to reset values. Stall held 2^CNT_W+2 cycles -> stall_cnt stays at 0xFFFF.
